// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared definitions for the UART transmitter:
//   - parity mode encodings (same meaning as the matching receiver)
//   - transmitter FSM state type
//   - helper functions: parity bit calculation, FIFO depth legality check
package uart_tx_pkg;

    // Parity mode encodings, derived from the PARITY string parameter
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Widest data word a frame can carry
    localparam int MAX_DATA_BITS = 8;

    // Transmitter FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Parity bit for a data word; unused upper bits must be zero so they
    // do not disturb the XOR reduction.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic [1:0] mode);
        logic p;
        p = ^data;
        case (mode)
            PAR_EVEN: return p;
            PAR_ODD:  return ~p;
            default:  return 1'b0;
        endcase
    endfunction

    // A FIFO depth is legal when it is a power of two and at least 2
    function automatic bit fifo_depth_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous FIFO buffering bytes in front of the UART serialiser.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write request and data (ignored while full)
//   pop             read request (ignored while empty)
//   rdata           head entry (valid while !empty)
//   count           number of entries held
//   full            registered full flag
//   empty           count == 0
// Pointers wrap naturally because DEPTH is a power of two.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    generate
        if (!fifo_depth_legal(DEPTH)) begin : g_depth_check
            $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             wr_en;
    logic             rd_en;

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign empty = (count == {CW{1'b0}});
    assign rdata = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel
    always_comb begin
        count_next = count;
        if (wr_en && !rd_en) begin
            count_next = count + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_next = count - CW'(1);
        end else begin
            count_next = count;
        end
    end

    // Pointers, occupancy and the registered full flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= {AW{1'b0}};
            rd_ptr <= {AW{1'b0}};
            count  <= {CW{1'b0}};
            full   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// UART transmitter: buffers words from a valid/ready source and sends each
// as start bit, DATA_BITS data bits LSB first, optional parity, stop bit(s).
// Bit timing comes only from the bd_rate strobe.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bd_rate      one-clock pulse per bit period
//   tx_data      word to send, sampled only when tx_valid && tx_ready
//   tx_valid     tx_data is valid this cycle
//   tx_ready     FIFO can accept a word (registered, = !full)
//   tx           serial line, idles high (registered)
//   tx_busy      a frame is in flight (registered)
//   fifo_count   words waiting in the FIFO
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int    DATA_BITS  = 8,
    parameter string PARITY     = "NONE",
    parameter int    STOP_BITS  = 1,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bd_rate,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [1:0] PAR_MODE = (PARITY == "EVEN") ? PAR_EVEN :
                                      ((PARITY == "ODD") ? PAR_ODD : PAR_NONE);
    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    // stop_cnt value at which the final stop bit is being sent
    localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    tx_state_t            state;
    tx_state_t            state_next;
    logic [DATA_BITS-1:0] sh;
    logic [DATA_BITS-1:0] sh_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_next;
    logic                 stop_cnt;
    logic                 stop_cnt_next;
    logic                 par_bit;
    logic                 par_next;
    logic                 tx_next;
    logic                 busy_next;

    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_ready = ~fifo_full;

    // Next-state logic: every transition waits for a bd_rate strobe
    always_comb begin
        state_next    = state;
        sh_next       = sh;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        par_next      = par_bit;
        tx_next       = tx;
        fifo_pop      = 1'b0;
        if (bd_rate) begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        sh_next    = fifo_rdata;
                        par_next   = calc_parity(MAX_DATA_BITS'(fifo_rdata), PAR_MODE);
                        tx_next    = 1'b0;
                        state_next = ST_START;
                    end else begin
                        tx_next    = 1'b1;
                    end
                end
                ST_START: begin
                    tx_next      = sh[0];
                    bit_cnt_next = {CNT_W{1'b0}};
                    state_next   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt != LAST_BIT) begin
                        // sh[1] becomes sh[0] after the shift, so it is the next bit out
                        sh_next      = sh >> 1;
                        tx_next      = sh[1];
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                    end else if (PAR_MODE != PAR_NONE) begin
                        tx_next    = par_bit;
                        state_next = ST_PARITY;
                    end else begin
                        tx_next       = 1'b1;
                        stop_cnt_next = 1'b0;
                        state_next    = ST_STOP;
                    end
                end
                ST_PARITY: begin
                    tx_next       = 1'b1;
                    stop_cnt_next = 1'b0;
                    state_next    = ST_STOP;
                end
                ST_STOP: begin
                    if (stop_cnt != LAST_STOP) begin
                        stop_cnt_next = 1'b1;
                    end else if (!fifo_empty) begin
                        // Back-to-back frame: start bit follows the last stop bit directly
                        fifo_pop   = 1'b1;
                        sh_next    = fifo_rdata;
                        par_next   = calc_parity(MAX_DATA_BITS'(fifo_rdata), PAR_MODE);
                        tx_next    = 1'b0;
                        state_next = ST_START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    tx_next    = 1'b1;
                    state_next = ST_IDLE;
                end
            endcase
        end else begin
            state_next = state;
        end
        busy_next = (state_next != ST_IDLE);
    end

    // FSM, shifter, counters and registered line outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sh       <= {DATA_BITS{1'b0}};
            bit_cnt  <= {CNT_W{1'b0}};
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_next;
            sh       <= sh_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            par_bit  <= par_next;
            tx       <= tx_next;
            tx_busy  <= busy_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
// Five transmitter configurations share clock, reset, bd_rate and the
// valid/data source. A frame-level reference model per configuration
// predicts the line value, busy, ready and FIFO occupancy every cycle.
module tb_uart_tx;

    localparam int NI = 5;
    localparam int NB [NI] = '{8, 8, 8, 8, 6};   // data bits
    localparam int PM [NI] = '{0, 0, 1, 2, 1};   // 0 none, 1 even, 2 odd
    localparam int SB [NI] = '{1, 2, 1, 1, 2};   // stop bits
    localparam int DP [NI] = '{4, 4, 4, 4, 2};   // FIFO depth

    logic       clk = 1'b0;
    logic       rst;
    logic       bd_rate;
    logic       tx_valid;
    logic [7:0] tx_data;

    logic       tx_o    [NI];
    logic       busy_o  [NI];
    logic       ready_o [NI];
    logic [2:0] cnt_o   [NI];
    logic [1:0] cnt_e;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0]  m_q    [NI][4];
    int          m_cnt  [NI];
    int          m_head [NI];
    logic        m_frm  [NI][16];
    int          m_len  [NI];
    int          m_pos  [NI];
    logic        m_line [NI];
    logic        m_busy [NI];
    logic        m_acc0;
    logic [31:0] cap    [NI];

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .PARITY("NONE"), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .bd_rate(bd_rate), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_o[0]), .tx(tx_o[0]), .tx_busy(busy_o[0]), .fifo_count(cnt_o[0]));
    uart_tx #(.DATA_BITS(8), .PARITY("NONE"), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .bd_rate(bd_rate), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_o[1]), .tx(tx_o[1]), .tx_busy(busy_o[1]), .fifo_count(cnt_o[1]));
    uart_tx #(.DATA_BITS(8), .PARITY("EVEN"), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .bd_rate(bd_rate), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_o[2]), .tx(tx_o[2]), .tx_busy(busy_o[2]), .fifo_count(cnt_o[2]));
    uart_tx #(.DATA_BITS(8), .PARITY("ODD"), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .rst(rst), .bd_rate(bd_rate), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_o[3]), .tx(tx_o[3]), .tx_busy(busy_o[3]), .fifo_count(cnt_o[3]));
    uart_tx #(.DATA_BITS(6), .PARITY("EVEN"), .STOP_BITS(2), .FIFO_DEPTH(2)) u_e (
        .clk(clk), .rst(rst), .bd_rate(bd_rate), .tx_data(tx_data[5:0]), .tx_valid(tx_valid),
        .tx_ready(ready_o[4]), .tx(tx_o[4]), .tx_busy(busy_o[4]), .fifo_count(cnt_e));

    assign cnt_o[4] = {1'b0, cnt_e};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_cnt[i]  = 0;
            m_head[i] = 0;
            m_len[i]  = 0;
            m_pos[i]  = 0;
            m_line[i] = 1'b1;
            m_busy[i] = 1'b0;
        end
    endtask

    // Frame bits in line order: start, data LSB first, parity, stops
    task automatic build_frame(input int i, input logic [7:0] d);
        logic p;
        p = 1'b0;
        m_frm[i][0] = 1'b0;
        m_len[i] = 1;
        for (int b = 0; b < NB[i]; b++) begin
            m_frm[i][m_len[i]] = d[b];
            p = p ^ d[b];
            m_len[i] = m_len[i] + 1;
        end
        if (PM[i] != 0) begin
            m_frm[i][m_len[i]] = (PM[i] == 1) ? p : ~p;
            m_len[i] = m_len[i] + 1;
        end
        for (int s = 0; s < SB[i]; s++) begin
            m_frm[i][m_len[i]] = 1'b1;
            m_len[i] = m_len[i] + 1;
        end
        m_pos[i] = 0;
    endtask

    // One clock edge: a bit period elapses on bd, then a push lands
    task automatic model_step(input logic bd, input logic v, input logic [7:0] d);
        m_acc0 = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                logic rdy;
                rdy = (m_cnt[i] < DP[i]);
                if (bd) begin
                    if (m_pos[i] < m_len[i]) begin
                        m_line[i] = m_frm[i][m_pos[i]];
                        m_pos[i]  = m_pos[i] + 1;
                        m_busy[i] = 1'b1;
                    end else if (m_cnt[i] > 0) begin
                        build_frame(i, m_q[i][m_head[i]]);
                        m_head[i] = (m_head[i] + 1) % DP[i];
                        m_cnt[i]  = m_cnt[i] - 1;
                        m_line[i] = m_frm[i][0];
                        m_pos[i]  = 1;
                        m_busy[i] = 1'b1;
                    end else begin
                        m_line[i] = 1'b1;
                        m_busy[i] = 1'b0;
                    end
                end
                if (v && rdy) begin
                    m_q[i][(m_head[i] + m_cnt[i]) % DP[i]] = d;
                    m_cnt[i] = m_cnt[i] + 1;
                    if (i == 0) m_acc0 = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("tx[%0d]", i),    32'(tx_o[i]),    32'(m_line[i]));
            check_eq($sformatf("busy[%0d]", i),  32'(busy_o[i]),  32'(m_busy[i]));
            check_eq($sformatf("ready[%0d]", i), 32'(ready_o[i]), 32'(m_cnt[i] < DP[i]));
            check_eq($sformatf("count[%0d]", i), 32'(cnt_o[i]),   32'(m_cnt[i]));
        end
    endtask

    task automatic run_cycle(input logic bd, input logic v, input logic [7:0] d);
        @(negedge clk);
        check_outputs();
        bd_rate  = bd;
        tx_valid = v;
        tx_data  = d;
        @(posedge clk);
        model_step(bd, v, d);
        #1;
        if (bd) begin
            for (int i = 0; i < NI; i++) cap[i] = {cap[i][30:0], tx_o[i]};
        end
    endtask

    task automatic clear_cap();
        for (int i = 0; i < NI; i++) cap[i] = 32'd0;
    endtask

    task automatic hit_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("rst_tx",    32'(tx_o[0]),    32'd1);
        check_eq("rst_busy",  32'(busy_o[0]),  32'd0);
        check_eq("rst_count", 32'(cnt_o[0]),   32'd0);
        check_eq("rst_ready", 32'(ready_o[0]), 32'd1);
        run_cycle(1'b0, 1'b0, 8'h00);
        run_cycle(1'b1, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        bd_rate  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        model_reset();
        clear_cap();
        repeat (3) run_cycle(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        repeat (2) run_cycle(1'b0, 1'b0, 8'h00);

        // single 0x66 frame, one bd pulse every third clock
        clear_cap();
        run_cycle(1'b0, 1'b1, 8'h66);
        for (int k = 0; k < 12; k++) begin
            run_cycle(1'b1, 1'b0, 8'h00);
            run_cycle(1'b0, 1'b0, 8'h00);
            run_cycle(1'b0, 1'b0, 8'h00);
        end
        check_eq("frame66_none",  cap[0][11:0], 32'b001100110111);
        check_eq("frame66_stop2", cap[1][11:0], 32'b001100110111);
        check_eq("frame66_even",  cap[2][11:0], 32'b001100110011);
        check_eq("frame66_odd",   cap[3][11:0], 32'b001100110111);
        check_eq("frame66_6bit",  cap[4][11:0], 32'b001100111111);

        // 0xA5 then 0x00 back to back, bd held high
        clear_cap();
        run_cycle(1'b0, 1'b1, 8'hA5);
        run_cycle(1'b0, 1'b1, 8'h00);
        repeat (24) run_cycle(1'b1, 1'b0, 8'h00);
        check_eq("a5_00_none",  cap[0][23:0], 32'b010100101100000000011111);
        check_eq("a5_00_stop2", cap[1][23:0], 32'b010100101110000000001111);
        check_eq("a5_00_even",  cap[2][23:0], 32'b010100101010000000000111);

        // five bytes into a four-deep FIFO
        for (int k = 1; k <= 4; k++) run_cycle(1'b0, 1'b1, 8'(k));
        check_eq("full_ready", 32'(ready_o[0]), 32'd0);
        check_eq("full_count", 32'(cnt_o[0]),   32'd4);
        for (int k = 0; k < 20 && !m_acc0; k++) run_cycle(k[0] == 1'b0, 1'b1, 8'h05);
        repeat (120) run_cycle(1'b1, 1'b0, 8'h00);

        // reset in the middle of the data bits, then a clean frame
        run_cycle(1'b0, 1'b1, 8'h3C);
        run_cycle(1'b0, 1'b1, 8'h11);
        run_cycle(1'b0, 1'b1, 8'h22);
        repeat (4) run_cycle(1'b1, 1'b0, 8'h00);
        hit_reset();
        clear_cap();
        run_cycle(1'b0, 1'b1, 8'h5A);
        for (int k = 0; k < 12; k++) begin
            run_cycle(1'b1, 1'b0, 8'h00);
            run_cycle(1'b0, 1'b0, 8'h00);
        end
        check_eq("frame5a_after_rst", cap[0][11:0], 32'b001011010111);

        // randomized traffic with varying bit rates and occasional resets
        for (int k = 0; k < 6000; k++) begin
            logic bd;
            logic v;
            case ((k / 500) % 3)
                0:       bd = ($urandom_range(0, 3) == 0);
                1:       bd = 1'b1;
                default: bd = ($urandom_range(0, 7) == 0);
            endcase
            v = ($urandom_range(0, 2) == 0);
            run_cycle(bd, v, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 999) == 0) hit_reset();
        end
        repeat (4) run_cycle(1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
